// File: rtl/imm_pkg.sv
// Shared immediate-extension definitions: mode encodings and the 2-bit mode type.
package imm_pkg;

  typedef logic [1:0] immMode_t;

  localparam immMode_t MODE_SIGN   = 2'b00;
  localparam immMode_t MODE_ZERO   = 2'b01;
  localparam immMode_t MODE_UPPER  = 2'b10;
  localparam immMode_t MODE_BRANCH = 2'b11;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extension: sign/zero fill, upper shift, branch (x4) offset,
// plus a flag for nonzero bits lost off the top in the shifting modes.
module imm_extend_core
  import imm_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int IMM_W       = 27,
  parameter int UPPER_SHIFT = 16
) (
  input  logic [DATA_W-1:0] instr,
  input  immMode_t          mode,
  output logic [DATA_W-1:0] data,
  output logic              ovf
);

  logic [DATA_W-1:0] zext;
  logic [DATA_W-1:0] sext;

  // Bitwise fill keeps IMM_W == DATA_W legal (no zero-width replication).
  always_comb begin
    zext = '0;
    sext = '0;
    for (int i = 0; i < DATA_W; i++) begin
      zext[i] = (i < IMM_W) ? instr[i] : 1'b0;
      sext[i] = (i < IMM_W) ? instr[i] : instr[IMM_W-1];
    end
  end

  always_comb begin
    data = '0;
    ovf  = 1'b0;
    unique case (mode)
      MODE_SIGN:  data = sext;
      MODE_ZERO:  data = zext;
      MODE_UPPER: begin
        data = zext << UPPER_SHIFT;
        for (int i = DATA_W - UPPER_SHIFT; i < DATA_W; i++) ovf = ovf | zext[i];
      end
      MODE_BRANCH: begin
        data = sext << 2;
        // Top three bits must agree or the x4 scaling changed the value.
        ovf  = (sext[DATA_W-1] != sext[DATA_W-2]) || (sext[DATA_W-2] != sext[DATA_W-3]);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with valid/ready handshake: one output register
// backed by a one-entry skid register so in_ready comes straight from a flop.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int IMM_W       = 27,
  parameter int UPPER_SHIFT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] instr,
  input  immMode_t          mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ovf
);

  logic [DATA_W-1:0] extData;
  logic              extOvf;
  logic [DATA_W-1:0] outData, skidData;
  logic              outOvf, skidOvf;
  logic              outValid, skidFull;
  logic              accept, drain, outFree;

  imm_extend_core #(
    .DATA_W      (DATA_W),
    .IMM_W       (IMM_W),
    .UPPER_SHIFT (UPPER_SHIFT)
  ) uCore (
    .instr (instr),
    .mode  (mode),
    .data  (extData),
    .ovf   (extOvf)
  );

  assign accept  = in_valid && !skidFull;
  assign drain   = outValid && out_ready;
  assign outFree = drain || !outValid;

  always_ff @(posedge clk) begin
    if (reset) begin
      outValid <= 1'b0;
      outData  <= '0;
      outOvf   <= 1'b0;
      skidFull <= 1'b0;
      skidData <= '0;
      skidOvf  <= 1'b0;
    end else if (outFree) begin
      // Skid is older than any new input, so it refills the output first.
      if (skidFull) begin
        outValid <= 1'b1;
        outData  <= skidData;
        outOvf   <= skidOvf;
        skidFull <= 1'b0;
      end else if (accept) begin
        outValid <= 1'b1;
        outData  <= extData;
        outOvf   <= extOvf;
      end else begin
        outValid <= 1'b0;
      end
    end else if (accept) begin
      skidFull <= 1'b1;
      skidData <= extData;
      skidOvf  <= extOvf;
    end
  end

  assign in_ready  = !skidFull;
  assign out_valid = outValid;
  assign out_data  = outData;
  assign out_ovf   = outOvf;

endmodule
